// File: rtl/pipelined_ripple_adder.sv
// pipelined_ripple_adder: WIDTH-bit add/subtract, carry chain cut into STAGES
// equal slices with a register stage after each slice. Valid/ready handshake on
// both sides, with per-stage bubble collapse.
//
// Optional feature macro: PIPELINED_RIPPLE_ADDER_OVF_EN
//   defined   -> extra output ovf (signed two's-complement overflow), pipelined with SUM
//   undefined -> no ovf port, no extra registers
//
// Ports:
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   operand transaction offered
//   in_ready   transaction accepted this cycle (combinational from state and out_ready)
//   A, B       operands (WIDTH bits)
//   ci         carry-in (add) / borrow-in (sub)
//   sub        0 = add, 1 = subtract
//   out_valid  result available
//   out_ready  consumer accepts result
//   SUM        result (WIDTH bits)
//   co         carry-out; in subtract mode 1 = no borrow
//   ovf        signed overflow (only with PIPELINED_RIPPLE_ADDER_OVF_EN)
module pipelined_ripple_adder #(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             ci,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] SUM,
    output logic             co
`ifdef PIPELINED_RIPPLE_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int unsigned SW   = WIDTH / STAGES;
    localparam int unsigned LAST = STAGES - 1;

    // Per-stage state: valid, carry out of the slice, operands, accumulated result
    logic [STAGES-1:0] v_q;
    logic [STAGES-1:0] c_q;
    logic [WIDTH-1:0]  a_q [STAGES];
    logic [WIDTH-1:0]  b_q [STAGES];
    logic [WIDTH-1:0]  r_q [STAGES];

    // Flow control
    logic [STAGES-1:0] adv;
    logic [STAGES-1:0] load;
    logic              nxt;

    // Datapath: what each stage sees at its input and what it would register
    logic [WIDTH-1:0]  a_src [STAGES];
    logic [WIDTH-1:0]  b_src [STAGES];
    logic [WIDTH-1:0]  r_src [STAGES];
    logic [WIDTH-1:0]  r_d   [STAGES];
    logic [STAGES-1:0] c_src;
    logic [STAGES-1:0] c_d;
    logic [SW:0]       slice;

    // Advance chain resolved from the output backwards so an empty stage
    // always pulls from its predecessor, even while the output is stalled.
    always_comb begin
        adv      = '0;
        load     = '0;
        in_ready = 1'b0;
        nxt      = v_q[LAST] & out_ready;
        adv[LAST] = nxt;
        for (int k = int'(STAGES) - 2; k >= 0; k--) begin
            nxt    = v_q[k] & (~v_q[k+1] | nxt);
            adv[k] = nxt;
        end
        in_ready = ~v_q[0] | adv[0];
        load[0]  = in_valid & in_ready;
        for (int k = 1; k < int'(STAGES); k++) begin
            load[k] = adv[k-1];
        end
    end

    // One SW-bit ripple slice per stage; stage 0 works on the live inputs
    // with B and carry-in inverted for subtract.
    always_comb begin
        c_src    = '0;
        c_d      = '0;
        slice    = '0;
        a_src[0] = A;
        b_src[0] = B ^ {WIDTH{sub}};
        c_src[0] = ci ^ sub;
        r_src[0] = '0;
        for (int k = 1; k < int'(STAGES); k++) begin
            a_src[k] = a_q[k-1];
            b_src[k] = b_q[k-1];
            c_src[k] = c_q[k-1];
            r_src[k] = r_q[k-1];
        end
        for (int k = 0; k < int'(STAGES); k++) begin
            slice = {1'b0, a_src[k][k*SW +: SW]}
                  + {1'b0, b_src[k][k*SW +: SW]}
                  + (SW+1)'(c_src[k]);
            r_d[k]               = r_src[k];
            r_d[k][k*SW +: SW]   = slice[SW-1:0];
            c_d[k]               = slice[SW];
        end
    end

    // Stage registers: valid follows the handshake, data loads only on accept
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q <= '0;
            c_q <= '0;
            for (int k = 0; k < int'(STAGES); k++) begin
                a_q[k] <= '0;
                b_q[k] <= '0;
                r_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < int'(STAGES); k++) begin
                v_q[k] <= load[k] | (v_q[k] & ~adv[k]);
                if (load[k]) begin
                    a_q[k] <= a_src[k];
                    b_q[k] <= b_src[k];
                    r_q[k] <= r_d[k];
                    c_q[k] <= c_d[k];
                end
            end
        end
    end

`ifdef PIPELINED_RIPPLE_ADDER_OVF_EN
    // Carry into the MSB recovered as a ^ b ^ sum at that bit
    logic ovf_d;

    always_comb begin
        ovf_d = a_src[LAST][WIDTH-1] ^ b_src[LAST][WIDTH-1]
              ^ r_d[LAST][WIDTH-1] ^ c_d[LAST];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf <= 1'b0;
        end else if (load[LAST]) begin
            ovf <= ovf_d;
        end
    end
`endif

    assign out_valid = v_q[LAST];
    assign SUM       = r_q[LAST];
    assign co        = c_q[LAST];

endmodule

// File: tb/tb_pipelined_ripple_adder.sv
// Self-checking bench for pipelined_ripple_adder (WIDTH=16, STAGES=4).
// With PIPELINED_RIPPLE_ADDER_OVF_EN defined, also checks ovf and an
// 8-bit / 2-stage instance.
module tb_pipelined_ripple_adder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        ci;
    logic        sub;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] sum;
    logic        co;
`ifdef PIPELINED_RIPPLE_ADDER_OVF_EN
    logic        ovf;
    logic        in_valid8, in_ready8, ci8, sub8, out_valid8, out_ready8, co8, ovf8;
    logic [7:0]  a8, b8, sum8;
`endif

    always #5 clk = ~clk;

    pipelined_ripple_adder #(.WIDTH(16), .STAGES(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .A(a), .B(b), .ci(ci), .sub(sub),
        .out_valid(out_valid), .out_ready(out_ready),
        .SUM(sum), .co(co)
`ifdef PIPELINED_RIPPLE_ADDER_OVF_EN
        , .ovf(ovf)
`endif
    );

`ifdef PIPELINED_RIPPLE_ADDER_OVF_EN
    pipelined_ripple_adder #(.WIDTH(8), .STAGES(2)) dut8 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid8), .in_ready(in_ready8),
        .A(a8), .B(b8), .ci(ci8), .sub(sub8),
        .out_valid(out_valid8), .out_ready(out_ready8),
        .SUM(sum8), .co(co8), .ovf(ovf8)
    );
`endif

    int n_cmp = 0;
    int n_bad = 0;
    int n_pop = 0;
    logic [17:0] exp_q[$];
    logic        stall_hold = 1'b0;
    logic [16:0] held;

    logic [15:0] va [8];
    logic [15:0] vb [8];
    logic        vc [8];
    logic        vs [8];

    // Reference: {ovf, co, sum} straight from the arithmetic definition
    function automatic logic [17:0] model(input logic [15:0] x, input logic [15:0] y,
                                          input logic c, input logic s);
        logic [15:0] ye;
        logic [16:0] r;
        logic        o;
        ye = s ? ~y : y;
        r  = {1'b0, x} + {1'b0, ye} + 17'(c ^ s);
        o  = (x[15] == ye[15]) && (r[15] != x[15]);
        return {o, r};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard: push on accept, pop and compare on output transfer,
    // and hold SUM/co steady across stalled cycles.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            stall_hold = 1'b0;
        end else begin
            if (stall_hold) begin
                check("stall_valid", 32'(out_valid), 32'd1);
                check("stall_hold", 32'({co, sum}), 32'(held));
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("spurious_out", 32'(out_valid), 32'd0);
                end else begin
                    logic [17:0] e;
                    e = exp_q.pop_front();
                    n_pop++;
                    check("sum", 32'(sum), 32'(e[15:0]));
                    check("co", 32'(co), 32'(e[16]));
`ifdef PIPELINED_RIPPLE_ADDER_OVF_EN
                    check("ovf", 32'(ovf), 32'(e[17]));
`endif
                end
            end
            stall_hold = out_valid && !out_ready;
            held       = {co, sum};
            if (in_valid && in_ready) exp_q.push_back(model(a, b, ci, sub));
        end
    end

    task automatic drive(input logic v, input logic [15:0] x, input logic [15:0] y,
                         input logic c, input logic s);
        @(posedge clk);
        #1;
        in_valid = v; a = x; b = y; ci = c; sub = s;
    endtask

    // Single transaction into an empty pipe, checking exact latency and literal result
    task automatic send_one(input logic [15:0] x, input logic [15:0] y, input logic c,
                            input logic s, input logic [15:0] es, input logic ec);
        logic got;
        got = 1'b0;
        drive(1'b1, x, y, c, s);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (in_ready) begin
                got = 1'b1;
                break;
            end
        end
        check("accept_wait", 32'(got), 32'd1);
        drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            if (i < 4) begin
                check("latency_early", 32'(out_valid), 32'd0);
            end else begin
                check("latency_valid", 32'(out_valid), 32'd1);
                check("sum_lit", 32'(sum), 32'(es));
                check("co_lit", 32'(co), 32'(ec));
            end
        end
    endtask

`ifdef PIPELINED_RIPPLE_ADDER_OVF_EN
    task automatic send8(input logic [7:0] x, input logic [7:0] y, input logic s,
                         input logic [7:0] es, input logic eo);
        logic got;
        got = 1'b0;
        @(posedge clk);
        #1;
        in_valid8 = 1'b1; a8 = x; b8 = y; ci8 = 1'b0; sub8 = s;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (in_ready8) begin
                got = 1'b1;
                break;
            end
        end
        check("accept8_wait", 32'(got), 32'd1);
        @(posedge clk);
        #1;
        in_valid8 = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (out_valid8) begin
                got = 1'b1;
                break;
            end
        end
        check("out8_wait", 32'(got), 32'd1);
        check("sum8_lit", 32'(sum8), 32'(es));
        check("ovf8_lit", 32'(ovf8), 32'(eo));
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        logic got;

        va[0] = 16'h1234; vb[0] = 16'h4321; vc[0] = 1'b1; vs[0] = 1'b0;
        va[1] = 16'h8000; vb[1] = 16'h8000; vc[1] = 1'b0; vs[1] = 1'b0;
        va[2] = 16'h0F0F; vb[2] = 16'hF0F1; vc[2] = 1'b0; vs[2] = 1'b0;
        va[3] = 16'h0000; vb[3] = 16'h0001; vc[3] = 1'b0; vs[3] = 1'b1;
        va[4] = 16'hABCD; vb[4] = 16'h1111; vc[4] = 1'b1; vs[4] = 1'b1;
        va[5] = 16'h7FFF; vb[5] = 16'h0001; vc[5] = 1'b0; vs[5] = 1'b0;
        va[6] = 16'h5555; vb[6] = 16'hAAAA; vc[6] = 1'b1; vs[6] = 1'b0;
        va[7] = 16'hFFFF; vb[7] = 16'hFFFF; vc[7] = 1'b0; vs[7] = 1'b1;

        rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; ci = 1'b0; sub = 1'b0;
        out_ready = 1'b1;
`ifdef PIPELINED_RIPPLE_ADDER_OVF_EN
        in_valid8 = 1'b0; a8 = '0; b8 = '0; ci8 = 1'b0; sub8 = 1'b0; out_ready8 = 1'b1;
`endif

        // Model sanity against hand-computed values
        check("model_add", 32'(model(16'hFFFF, 16'h0001, 1'b0, 1'b0)), 32'h10000);
        check("model_sub", 32'(model(16'h0005, 16'h0007, 1'b0, 1'b1)), 32'h0FFFE);
        check("model_ovf", 32'(model(16'h7FFF, 16'h0001, 1'b0, 1'b0)), 32'h28000);

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_sum", 32'(sum), 32'd0);
        check("rst_co", 32'(co), 32'd0);
        @(posedge clk);
        #3 rst_n = 1'b1;
        @(negedge clk);
        check("rel_in_ready", 32'(in_ready), 32'd1);

        // Directed single transactions
        send_one(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1);
        send_one(16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0);
        send_one(16'h0007, 16'h0005, 1'b1, 1'b1, 16'h0001, 1'b1);
        send_one(16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0);
        send_one(16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1);

        // Back-to-back stream: full throughput, results on 8 consecutive cycles
        for (int i = 0; i < 13; i++) begin
            if (i < 8) drive(1'b1, va[i], vb[i], vc[i], vs[i]);
            else       drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
            @(negedge clk);
            if (i < 8) check("stream_in_ready", 32'(in_ready), 32'd1);
            check("stream_out_valid", 32'(out_valid), 32'((i >= 4) && (i < 12)));
        end

        // Backpressure: fill with the output stalled, hold, then release
        base = n_pop;
        for (int j = 0; j < 9; j++) begin
            if (j == 0) begin
                @(posedge clk);
                #1 out_ready = 1'b0;
                in_valid = 1'b1; a = va[0]; b = vb[0]; ci = vc[0]; sub = vs[0];
            end else begin
                drive(1'b1, va[j < 4 ? j : 4], vb[j < 4 ? j : 4], vc[j < 4 ? j : 4],
                      vs[j < 4 ? j : 4]);
            end
            @(negedge clk);
            if (j < 4) begin
                check("bp_fill_ready", 32'(in_ready), 32'd1);
            end else begin
                check("bp_full_ready", 32'(in_ready), 32'd0);
                check("bp_full_valid", 32'(out_valid), 32'd1);
            end
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (in_ready) begin
                got = 1'b1;
                break;
            end
        end
        check("bp_release_accept", 32'(got), 32'd1);
        drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!out_valid) begin
                got = 1'b1;
                break;
            end
        end
        check("bp_drain", 32'(got), 32'd1);
        @(posedge clk);
        #1;
        check("bp_pop_count", 32'(n_pop - base), 32'd5);
        check("bp_queue_empty", 32'(exp_q.size()), 32'd0);

        // Asynchronous reset mid-stream
        for (int i = 0; i < 6; i++) drive(1'b1, va[i], vb[i], vc[i], vs[i]);
        @(posedge clk);
        #2;
        check("pre_rst_valid", 32'(out_valid), 32'd1);
        #1 rst_n = 1'b0;
        in_valid = 1'b0;
        #1;
        check("async_rst_valid", 32'(out_valid), 32'd0);
        check("async_rst_sum", 32'(sum), 32'd0);
        check("async_rst_co", 32'(co), 32'd0);
        @(posedge clk);
        #3 rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_ready", 32'(in_ready), 32'd1);
        for (int i = 0; i < 4; i++) begin
            check("post_rst_stale", 32'(out_valid), 32'd0);
            @(negedge clk);
        end
        send_one(16'h0F0F, 16'hF0F1, 1'b0, 1'b0, 16'h0000, 1'b1);

`ifdef PIPELINED_RIPPLE_ADDER_OVF_EN
        send8(8'h7F, 8'h01, 1'b0, 8'h80, 1'b1);
        send8(8'h80, 8'h01, 1'b1, 8'h7F, 1'b1);
        send8(8'h10, 8'h20, 1'b0, 8'h30, 1'b0);
`endif

        repeat (3) @(posedge clk);
        #1;
        check("final_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
